// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM types, defaults and lane-index helper
package tdm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } tdm_state_e;

  localparam int NCH_DEF   = 16;
  localparam int SEL_W_DEF = 4;

  // Low bit index of lane k in a packed NCH*w word.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/tdm_slot_dec_onehot.sv
// rtl/tdm_slot_dec_onehot.sv - slot index to one-hot lane write enable
module slot_dec_onehot #(
  parameter int NCH   = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NCH-1:0]   we_o
);

  assign we_o = en_i ? (NCH'(1) << sel_i) : '0;

endmodule

// File: rtl/tdm_demux_1to16.sv
// rtl/tdm_demux_1to16.sv - TDM serial-to-parallel frame demultiplexer
module tdm_demux_1to16
  import tdm_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int DATA_W = 1,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [NCH*DATA_W-1:0] dout,
  output logic                  dout_valid,
  output logic [SEL_W-1:0]      slot,
  output logic                  sync_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);
  localparam int               LAST_LO   = lane_lo(NCH - 1, DATA_W);

  tdm_state_e              state_q, state_d;
  logic [SEL_W-1:0]        slot_q, slot_d;
  logic [NCH*DATA_W-1:0]   shadow_q;
  logic [NCH*DATA_W-1:0]   dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic                    wr_en;
  logic [SEL_W-1:0]        wr_sel;
  logic [NCH-1:0]          lane_we;

  // A sync beat always lands in lane 0, whatever slot the counter was at.
  assign wr_sel = frame_sync ? '0 : slot_q;

  slot_dec_onehot #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i (wr_sel),
    .en_i  (wr_en),
    .we_o  (lane_we)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_sync) begin
            wr_en   = 1'b1;
            slot_d  = SEL_W'(1);
            state_d = ST_RECV;
          end
        end
        ST_RECV: begin
          if (frame_sync) begin
            wr_en      = 1'b1;
            sync_err_d = 1'b1;
            slot_d     = SEL_W'(1);
          end else if (slot_q == LAST_SLOT) begin
            // Last lane bypasses the shadow so the frame is complete at this edge.
            dout_d                          = shadow_q;
            dout_d[LAST_LO +: DATA_W]       = din;
            dout_valid_d                    = 1'b1;
            slot_d                          = '0;
            state_d                         = ST_IDLE;
          end else begin
            wr_en  = 1'b1;
            slot_d = slot_q + SEL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (lane_we[k]) shadow_q[lane_lo(k, DATA_W) +: DATA_W] <= din;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to16.sv
// tb/tb_tdm_demux_1to16.sv - self-checking bench for tdm_demux_1to16
module tb_tdm_demux_1to16;

  logic        clk;
  logic        rst_n;
  logic [0:0]  din;
  logic        din_valid;
  logic        frame_sync;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  slot;
  logic        sync_err;

  int n_chk;
  int n_fail;
  int cyc;
  int strobe_cnt;
  int err_cnt;
  int last_strobe_cyc;
  int prev_strobe_cyc;
  logic [15:0] exp_q[$];

  tdm_demux_1to16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each strobe pops the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        logic [15:0] e;
        strobe_cnt++;
        prev_strobe_cyc = last_strobe_cyc;
        last_strobe_cyc = cyc;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_strobe: dout=%h with no frame expected", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_fail++;
            $display("FAIL sb_dout: got %h expected %h", dout, e);
          end
        end
      end
      if (sync_err) err_cnt++;
      if (dout_valid && sync_err) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe_overlap: dout_valid=%b sync_err=%b expected not both", dout_valid, sync_err);
      end
    end
  end

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
  endtask

  task automatic stall();
    @(negedge clk);
    din        = 1'($urandom);
    din_valid  = 1'b0;
    frame_sync = 1'($urandom);
  endtask

  task automatic send_frame(input logic [15:0] pat);
    exp_q.push_back(pat);
    for (int k = 0; k < 16; k++) beat(pat[k], k == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    cyc = 0; strobe_cnt = 0; err_cnt = 0; last_strobe_cyc = 0; prev_strobe_cyc = 0;
    n_chk = 0; n_fail = 0;
    #1;
    n_chk++;
    if ({dout, dout_valid, slot, sync_err} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_state: dout=%h dv=%b slot=%0d se=%b expected all 0", dout, dout_valid, slot, sync_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [15:0] pat;
    pat = 16'hA5C3;
    send_frame(pat);
    stall();
    n_chk++;
    if (dout_valid !== 1'b1 || dout !== pat) begin
      n_fail++;
      $display("FAIL full_latency: dv=%b dout=%h expected dv=1 dout=%h", dout_valid, dout, pat);
    end
    n_chk++;
    if (slot !== 4'd0) begin
      n_fail++;
      $display("FAIL full_slot_back_to_0: slot=%0d expected 0", slot);
    end
    stall();
    n_chk++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_strobe_width: dv=%b expected 0", dout_valid);
    end
  endtask

  task automatic test_stalls();
    logic [15:0] pat;
    int s0;
    pat = 16'hA5C3;
    s0  = strobe_cnt;
    exp_q.push_back(pat);
    for (int k = 0; k < 16; k++) begin
      beat(pat[k], k == 0);
      if (k == 4 || k == 11) begin
        for (int j = 0; j < 3; j++) begin
          stall();
          n_chk++;
          if (slot !== 4'(k + 1)) begin
            n_fail++;
            $display("FAIL stall_slot_hold: slot=%0d expected %0d", slot, k + 1);
          end
        end
      end
    end
    repeat (2) stall();
    n_chk++;
    if (strobe_cnt - s0 !== 1 || dout !== pat) begin
      n_fail++;
      $display("FAIL stall_frame: strobes=%0d dout=%h expected 1 and %h", strobe_cnt - s0, dout, pat);
    end
  endtask

  task automatic test_early_sync();
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 7; k++) beat(1'($urandom), k == 0);
    exp_q.push_back(16'h1234);
    for (int k = 0; k < 16; k++) begin
      beat(k == 0 ? 1'b0 : 1'(16'h1234 >> k), k == 0);
      if (k == 1) begin
        n_chk++;
        if (sync_err !== 1'b1) begin
          n_fail++;
          $display("FAIL early_sync_strobe: sync_err=%b expected 1", sync_err);
        end
      end
      if (k == 15) begin
        n_chk++;
        if (dout !== 16'hA5C3) begin
          n_fail++;
          $display("FAIL early_sync_dout_kept: dout=%h expected a5c3", dout);
        end
      end
    end
    repeat (2) stall();
    n_chk++;
    if (err_cnt - e0 !== 1 || dout !== 16'h1234) begin
      n_fail++;
      $display("FAIL early_sync_result: errs=%0d dout=%h expected 1 and 1234", err_cnt - e0, dout);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    send_frame(16'hFFFF);
    send_frame(16'h0001);
    repeat (2) stall();
    n_chk++;
    if (strobe_cnt - s0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_strobes: got %0d expected 2", strobe_cnt - s0);
    end
    n_chk++;
    if (last_strobe_cyc - prev_strobe_cyc !== 16) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles expected 16", last_strobe_cyc - prev_strobe_cyc);
    end
  endtask

  task automatic test_idle_noise();
    int s0;
    logic [15:0] d0;
    s0 = strobe_cnt;
    d0 = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      beat(1'($urandom), 1'b0);
      @(posedge clk); #1;
      n_chk++;
      if (slot !== 4'd0) begin
        n_fail++;
        $display("FAIL idle_slot: slot=%0d expected 0", slot);
      end
    end
    repeat (2) stall();
    n_chk++;
    if (strobe_cnt !== s0 || dout !== d0) begin
      n_fail++;
      $display("FAIL idle_noise: strobes=%0d dout=%h expected %0d and %h", strobe_cnt - s0, dout, 0, d0);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) beat(1'b1, k == 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (dout !== 16'h0 || dout_valid !== 1'b0 || slot !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: dout=%h dv=%b slot=%0d expected 0 0 0", dout, dout_valid, slot);
    end
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(16'h8421);
    repeat (2) stall();
    n_chk++;
    if (dout !== 16'h8421) begin
      n_fail++;
      $display("FAIL post_reset_frame: dout=%h expected 8421", dout);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stalls();
    test_early_sync();
    test_back_to_back();
    test_idle_noise();
    test_async_reset();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d frames pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
